// File: rtl/counter_chk_pkg.sv
// counter_chk_pkg
// Shared definitions for the counter checker and its reference model.
// Contents:
//   chk_state_t   - checker FSM state (IDLE, CHECK, FAIL), 2-bit encoding
//   DEFAULT_WIDTH - default counter/data width
//   DEFAULT_ERR_W - default saturating error-counter width
//   MAX_W         - widest counter the shared next_count helper supports
//   next_count()  - one-step load/enable/up-down counter model
package counter_chk_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_ERR_W = 8;
  localparam int MAX_W         = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FAIL  = 2'd2
  } chk_state_t;

  // The helper works at MAX_W bits. Callers truncate the result back to
  // their own width. Wrap-around modulo 2^WIDTH is preserved because
  // +1/-1 on the low bits does not depend on the upper bits.
  function automatic logic [MAX_W-1:0] next_count(
    input logic [MAX_W-1:0] base,
    input logic [MAX_W-1:0] data_in,
    input logic             load,
    input logic             enable,
    input logic             up_down
  );
    logic [MAX_W-1:0] result;
    if (load)
      result = data_in;
    else if (enable && up_down)
      result = base + 64'd1;
    else if (enable)
      result = base - 64'd1;
    else
      result = base;
    return result;
  endfunction

endpackage

// File: rtl/counter_model.sv
// counter_model
// Pure combinational next-value model of the 16-bit load/enable/up-down
// counter. It is kept as its own module so the same model can drive both
// the checker and a bench scoreboard.
// Ports:
//   base       in  WIDTH  current count to advance
//   data_in    in  WIDTH  load value
//   load       in  1      load control (wins over enable)
//   enable     in  1      count enable
//   up_down    in  1      1 = up, 0 = down
//   next_value out WIDTH  count after one clock edge
module counter_model
  import counter_chk_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_value
);

  assign next_value = WIDTH'(next_count(MAX_W'(base), MAX_W'(data_in),
                                        load, enable, up_down));

endmodule

// File: rtl/counter_checker.sv
// counter_checker
// Observer for a load/enable/up-down counter. It sees the same controls as
// the counter and the counter's output. It keeps a cycle-accurate
// prediction, pulses mismatch one cycle after each divergence, counts
// errors (saturating), and captures the first failing expected/actual pair.
// Ports:
//   clk          in  1      rising-edge clock shared with the counter
//   reset        in  1      synchronous, active-low reset
//   chk_en       in  1      enable checking (low = track only)
//   clr          in  1      synchronous clear of error state/statistics
//   data_in      in  WIDTH  counter load value
//   load         in  1      counter load control
//   enable       in  1      counter count enable
//   up_down      in  1      1 = count up, 0 = count down
//   dut_data_out in  WIDTH  observed counter output
//   expected     out WIDTH  current predicted count
//   mismatch     out 1      one-cycle pulse per detected error
//   err_cnt      out ERR_W  saturating error count
//   first_exp    out WIDTH  expected value at the first error
//   first_act    out WIDTH  observed value at the first error
//   fail         out 1      sticky error flag since reset/clr
//   state        out 2      0 = IDLE, 1 = CHECK, 2 = FAIL
// Optional build macro: COUNTER_CHECKER_RESYNC_EN. When it is defined, a
// mismatch re-bases the prediction on the observed value, so a single bad
// step is reported once instead of on every later cycle.
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int ERR_W        = DEFAULT_ERR_W,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chk_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             enable,
  input  logic             up_down,
  input  logic [WIDTH-1:0] dut_data_out,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act,
  output logic             fail,
  output logic [1:0]       state
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  chk_state_t       cur_state;
  logic [WIDTH-1:0] next_from_exp;
  logic [WIDTH-1:0] next_from_obs;
  logic [WIDTH-1:0] next_after_err;

  // Two copies of the model: one advances our own prediction, the other
  // re-syncs to whatever the counter is actually showing.
  counter_model #(.WIDTH(WIDTH)) u_model_exp (
    .base       (expected),
    .data_in    (data_in),
    .load       (load),
    .enable     (enable),
    .up_down    (up_down),
    .next_value (next_from_exp)
  );

  counter_model #(.WIDTH(WIDTH)) u_model_obs (
    .base       (dut_data_out),
    .data_in    (data_in),
    .load       (load),
    .enable     (enable),
    .up_down    (up_down),
    .next_value (next_from_obs)
  );

`ifdef COUNTER_CHECKER_RESYNC_EN
  assign next_after_err = next_from_obs;
`else
  assign next_after_err = next_from_exp;
`endif

  assign state = cur_state;

  // The FSM, prediction, error statistics and first-failure capture all
  // live in one block so that reset > clr > normal operation is explicit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state <= IDLE;
      expected  <= '0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      first_exp <= '0;
      first_act <= '0;
      fail      <= 1'b0;
    end else if (clr) begin
      cur_state <= IDLE;
      expected  <= next_from_obs;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      first_exp <= '0;
      first_act <= '0;
      fail      <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (cur_state)
        IDLE: begin
          expected <= next_from_obs;
          if (chk_en)
            cur_state <= CHECK;
        end
        CHECK: begin
          if (!chk_en) begin
            // Leaving CHECK skips this edge's compare and keeps tracking.
            expected  <= next_from_obs;
            cur_state <= IDLE;
          end else if (dut_data_out != expected) begin
            mismatch <= 1'b1;
            fail     <= 1'b1;
            if (err_cnt != ERR_MAX)
              err_cnt <= err_cnt + 1'b1;
            if (!fail) begin
              first_exp <= expected;
              first_act <= dut_data_out;
            end
            expected <= next_after_err;
            if (STOP_ON_FAIL != 0)
              cur_state <= FAIL;
          end else begin
            expected <= next_from_exp;
          end
        end
        FAIL: begin
          expected <= next_from_obs;
        end
        default: begin
          expected  <= next_from_obs;
          cur_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker
// Directed bench for counter_checker. The counter output is driven directly
// as hand-chosen values, so both correct and faulty counters can be modelled.
// u_main runs with STOP_ON_FAIL = 0 and u_stop with STOP_ON_FAIL = 1. Both
// instances see the same stimulus.
module tb_counter_checker;

  logic        clk;
  logic        reset;
  logic        chk_en;
  logic        clr;
  logic [15:0] data_in;
  logic        load;
  logic        enable;
  logic        up_down;
  logic [15:0] dut_data_out;

  logic [15:0] m_expected, s_expected;
  logic        m_mismatch, s_mismatch;
  logic [7:0]  m_err_cnt, s_err_cnt;
  logic [15:0] m_first_exp, s_first_exp;
  logic [15:0] m_first_act, s_first_act;
  logic        m_fail, s_fail;
  logic [1:0]  m_state, s_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_after_err;
  logic [7:0]  exp_offset_errs;

  counter_checker #(.WIDTH(16), .ERR_W(8), .STOP_ON_FAIL(0)) u_main (
    .clk          (clk),
    .reset        (reset),
    .chk_en       (chk_en),
    .clr          (clr),
    .data_in      (data_in),
    .load         (load),
    .enable       (enable),
    .up_down      (up_down),
    .dut_data_out (dut_data_out),
    .expected     (m_expected),
    .mismatch     (m_mismatch),
    .err_cnt      (m_err_cnt),
    .first_exp    (m_first_exp),
    .first_act    (m_first_act),
    .fail         (m_fail),
    .state        (m_state)
  );

  counter_checker #(.WIDTH(16), .ERR_W(8), .STOP_ON_FAIL(1)) u_stop (
    .clk          (clk),
    .reset        (reset),
    .chk_en       (chk_en),
    .clr          (clr),
    .data_in      (data_in),
    .load         (load),
    .enable       (enable),
    .up_down      (up_down),
    .dut_data_out (dut_data_out),
    .expected     (s_expected),
    .mismatch     (s_mismatch),
    .err_cnt      (s_err_cnt),
    .first_exp    (s_first_exp),
    .first_act    (s_first_act),
    .fail         (s_fail),
    .state        (s_state)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of counter controls and the observed value. Then step
  // past the next rising edge so that outputs are sampled 1 time unit later.
  task automatic applyStimulus(input logic ld, input logic en, input logic ud,
                               input logic [15:0] din, input logic [15:0] dout);
    load         = ld;
    enable       = en;
    up_down      = ud;
    data_in      = din;
    dut_data_out = dout;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  initial begin
`ifdef COUNTER_CHECKER_RESYNC_EN
    exp_after_err   = 16'h0105;
    exp_offset_errs = 8'd1;
`else
    exp_after_err   = 16'h0104;
    exp_offset_errs = 8'd5;
`endif
    reset  = 1'b0;
    chk_en = 1'b0;
    clr    = 1'b0;
    @(negedge clk);

    // Reset state.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678);
    checkOutput("rst_expected", 32'(m_expected), 32'h0);
    checkOutput("rst_mismatch", 32'(m_mismatch), 32'h0);
    checkOutput("rst_err_cnt", 32'(m_err_cnt), 32'h0);
    checkOutput("rst_fail", 32'(m_fail), 32'h0);
    checkOutput("rst_state", 32'(m_state), 32'h0);

    // Load 00FF from IDLE, then count up three times with a correct counter.
    reset  = 1'b1;
    chk_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000);
    checkOutput("load_expected", 32'(m_expected), 32'h00FF);
    checkOutput("load_state", 32'(m_state), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF);
    checkOutput("up1_expected", 32'(m_expected), 32'h0100);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0100);
    checkOutput("up2_expected", 32'(m_expected), 32'h0101);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0101);
    checkOutput("up3_expected", 32'(m_expected), 32'h0102);
    checkOutput("up3_mismatch", 32'(m_mismatch), 32'h0);
    checkOutput("up3_err_cnt", 32'(m_err_cnt), 32'h0);

    // Wrap boundaries: FFFF up to 0000, 0000 down to FFFF.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0102);
    checkOutput("ldffff_expected", 32'(m_expected), 32'hFFFF);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF);
    checkOutput("wrap_up_expected", 32'(m_expected), 32'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("ld0000_expected", 32'(m_expected), 32'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1111, 16'h0000);
    checkOutput("wrap_dn_expected", 32'(m_expected), 32'hFFFF);
    checkOutput("wrap_err_cnt", 32'(m_err_cnt), 32'h0);
    checkOutput("wrap_fail", 32'(m_fail), 32'h0);

    // Single wrong value: 0105 observed while 0104 is expected.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0104, 16'hFFFF);
    checkOutput("pre_err_mismatch", 32'(m_mismatch), 32'h0);
    checkOutput("pre_err_expected", 32'(m_expected), 32'h0104);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0105);
    checkOutput("err_mismatch", 32'(m_mismatch), 32'h1);
    checkOutput("err_err_cnt", 32'(m_err_cnt), 32'h1);
    checkOutput("err_first_exp", 32'(m_first_exp), 32'h0104);
    checkOutput("err_first_act", 32'(m_first_act), 32'h0105);
    checkOutput("err_fail", 32'(m_fail), 32'h1);
    checkOutput("err_expected", 32'(m_expected), 32'(exp_after_err));
    checkOutput("stop_state", 32'(s_state), 32'h2);
    checkOutput("stop_err_cnt", 32'(s_err_cnt), 32'h1);

    // The pulse lasts one cycle; the stopped checker stays in FAIL.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0200, exp_after_err);
    checkOutput("post_err_mismatch", 32'(m_mismatch), 32'h0);
    checkOutput("post_err_err_cnt", 32'(m_err_cnt), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0300);
    checkOutput("stop_hold_state", 32'(s_state), 32'h2);
    checkOutput("stop_hold_err_cnt", 32'(s_err_cnt), 32'h1);

    // clr returns both checkers to IDLE with clean statistics.
    clr = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200);
    clr = 1'b0;
    checkOutput("clr_expected", 32'(m_expected), 32'h0201);
    checkOutput("clr_err_cnt", 32'(m_err_cnt), 32'h0);
    checkOutput("clr_fail", 32'(m_fail), 32'h0);
    checkOutput("clr_first_exp", 32'(m_first_exp), 32'h0);
    checkOutput("clr_state", 32'(m_state), 32'h0);
    checkOutput("stop_clr_state", 32'(s_state), 32'h0);
    checkOutput("stop_clr_err_cnt", 32'(s_err_cnt), 32'h0);
    checkOutput("stop_clr_first_act", 32'(s_first_act), 32'h0);

    // Persistent +1 offset for five cycles while counting up.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0201);
    checkOutput("ofs_sync_expected", 32'(m_expected), 32'h0202);
    checkOutput("ofs_sync_state", 32'(m_state), 32'h1);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0203 + 16'(i));
    checkOutput("ofs_err_cnt", 32'(m_err_cnt), 32'(exp_offset_errs));
    checkOutput("ofs_first_exp", 32'(m_first_exp), 32'h0202);
    checkOutput("ofs_first_act", 32'(m_first_act), 32'h0203);
    checkOutput("stop_ofs_err_cnt", 32'(s_err_cnt), 32'h1);
    checkOutput("stop_ofs_state", 32'(s_state), 32'h2);

    // clr on the same edge as a mismatch: clr wins and nothing is recorded.
    clr = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF);
    clr = 1'b0;
    checkOutput("clr_vs_err_mismatch", 32'(m_mismatch), 32'h0);
    checkOutput("clr_vs_err_err_cnt", 32'(m_err_cnt), 32'h0);
    checkOutput("clr_vs_err_expected", 32'(m_expected), 32'h0000);

    // Saturation: 300 forced mismatches on an 8-bit error counter.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001);
      if (i == 254) checkOutput("sat_254", 32'(m_err_cnt), 32'hFE);
      if (i == 255) checkOutput("sat_255", 32'(m_err_cnt), 32'hFF);
    end
    checkOutput("sat_300", 32'(m_err_cnt), 32'hFF);
    checkOutput("sat_mismatch", 32'(m_mismatch), 32'h1);
    checkOutput("stop_sat_err_cnt", 32'(s_err_cnt), 32'h1);

    // Reset in the middle of the error stream.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001);
    checkOutput("midrst_expected", 32'(m_expected), 32'h0);
    checkOutput("midrst_mismatch", 32'(m_mismatch), 32'h0);
    checkOutput("midrst_err_cnt", 32'(m_err_cnt), 32'h0);
    checkOutput("midrst_first_exp", 32'(m_first_exp), 32'h0);
    checkOutput("midrst_first_act", 32'(m_first_act), 32'h0);
    checkOutput("midrst_fail", 32'(m_fail), 32'h0);
    checkOutput("midrst_state", 32'(m_state), 32'h0);
    checkOutput("stop_midrst_state", 32'(s_state), 32'h0);

    // Dropping chk_en in CHECK skips that edge's compare.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010);
    checkOutput("chk_hold_expected", 32'(m_expected), 32'h0010);
    chk_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0999);
    checkOutput("chk_off_state", 32'(m_state), 32'h0);
    checkOutput("chk_off_mismatch", 32'(m_mismatch), 32'h0);
    checkOutput("chk_off_err_cnt", 32'(m_err_cnt), 32'h0);
    checkOutput("chk_off_expected", 32'(m_expected), 32'h0999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side, observer end of the 16-bit load/enable/up-down counter interface.
- Sits beside the counter and samples the same load, enable, up_down and data_in controls plus the counter's data_out.
- Keeps a cycle-accurate expected count and flags every divergence. It captures the first failing pair and counts errors.
- Used in bug-hunt benches and as an in-system self-check.

Parameters:
- WIDTH, 16, counter/data width.
- ERR_W, 8, error-counter width (saturating).
- STOP_ON_FAIL, 0, 1 = enter FAIL and stop comparing after the first mismatch.

Ports:
- clk  input  1  rising-edge clock shared with the counter.
- reset  input  1  synchronous, active-low reset.
- chk_en  input  1  enables checking; low = track-only.
- clr  input  1  synchronous clear of error state/statistics.
- data_in  input  WIDTH  counter load value, same as the counter sees.
- load  input  1  counter load control.
- enable  input  1  counter count enable.
- up_down  input  1  1 = count up, 0 = count down.
- dut_data_out  input  WIDTH  observed counter output.
- expected  output  WIDTH  current predicted count.
- mismatch  output  1  one-cycle pulse per detected error.
- err_cnt  output  ERR_W  saturating error count.
- first_exp  output  WIDTH  expected value at the first error.
- first_act  output  WIDTH  observed value at the first error.
- fail  output  1  sticky: at least one error since reset/clr.
- state  output  2  0 = IDLE, 1 = CHECK, 2 = FAIL.

Behaviour:
- Reset (reset == 0 at a rising edge): expected = 0, mismatch = 0, err_cnt = 0, first_exp = 0, first_act = 0, fail = 0, state = IDLE.
- Counter model, next(b):
  - load: data_in (highest priority).
  - else enable and up_down: b + 1, modulo 2^WIDTH (FFFF -> 0000).
  - else enable: b - 1, modulo 2^WIDTH (0000 -> FFFF).
  - else: b.
- Compare at each edge: dut_data_out against expected, both the values present before that edge.
- IDLE:
  - expected <= next(dut_data_out); this syncs to the counter and performs no compare.
  - chk_en == 1 -> CHECK.
- CHECK, values equal:
  - expected <= next(expected).
- CHECK, values differ:
  - mismatch = 1 for exactly the following cycle.
  - err_cnt increments and saturates at 2^ERR_W - 1.
  - fail <= 1.
  - If fail was 0, first_exp/first_act capture expected/dut_data_out.
  - expected <= next(expected).
  - STOP_ON_FAIL == 1 -> FAIL.
- CHECK exit: chk_en == 0 -> IDLE, and that edge's compare is skipped.
- FAIL:
  - No compares; expected tracks via next(dut_data_out).
  - Exit only via clr or reset.
- clr (priority below reset):
  - err_cnt, first_exp, first_act, fail <= 0; mismatch <= 0.
  - state <= IDLE.
  - expected <= next(dut_data_out).
- Simultaneous events:
  - load and enable together: load wins.
  - clr and a mismatch at the same edge: clr wins, nothing is recorded.
- Latency: a wrong DUT value is visible on mismatch one cycle after the edge on which it was sampled.

Optional Feature:
- Macro: COUNTER_CHECKER_RESYNC_EN.
- Defined: on a CHECK mismatch, expected <= next(dut_data_out), so one bad step gives one error and is not re-reported every following cycle.
- Undefined: expected <= next(expected); a persistent offset reports every cycle until the values coincide again.

Decomposition:
- Package counter_chk_pkg holds:
  - state enum (IDLE, CHECK, FAIL);
  - default WIDTH/ERR_W localparams;
  - a function next_count(base, data_in, load, enable, up_down).
- Sub-module counter_model: a pure combinational next-value wrapper, so the same model serves the bench scoreboard.
- The FSM, error counter and capture registers stay in counter_checker.

Test Plan:
- Reset, chk_en = 1, load = 1, data_in = 16'h00FF, then 3 cycles enable = 1, up_down = 1, DUT correct -> expected 0100, 0101, 0102; mismatch never 1; err_cnt = 0.
- Load FFFF, count up 1 -> expected 0000. Load 0000, count down 1 -> expected FFFF. Correct DUT -> no error.
- DUT returns 0105 when 0104 is expected -> mismatch pulse 1 cycle later; err_cnt = 1; first_exp = 0104; first_act = 0105; fail = 1.
- RESYNC defined, DUT offset +1 persists 5 cycles -> err_cnt = 1. Undefined -> err_cnt = 5.
- STOP_ON_FAIL = 1, two bad values -> state = FAIL after the first, err_cnt = 1. Then clr -> state IDLE, all stats 0.
- 300 forced mismatches with ERR_W = 8 -> err_cnt holds at FF. Reset asserted mid-count -> all outputs back to reset values on that edge.
